// File: rtl/save_state_initiator.sv
// Save-state bus initiator: streams a header plus WORD_COUNT words of core-local
// state to the save-state controller on a save, and writes them back on a load.
module save_state_initiator #(
  parameter int unsigned WORD_COUNT = 512,
  parameter logic [25:0] ADDR_BASE  = 26'h0,
  parameter logic [31:0] MAGIC      = 32'h4E455331
) (
  input  logic        clk_ppu_21_47,
  input  logic        reset_n,
  input  logic        ss_save,
  input  logic        ss_load,
  output logic        ss_req,
  output logic        ss_rnw,
  output logic [25:0] ss_addr,
  output logic [7:0]  ss_be,
  output logic [63:0] ss_dout,
  input  logic [63:0] ss_din,
  input  logic        ss_ack,
  output logic        ss_busy,
  output logic        core_pause,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        load_err
);

  // state   | meaning
  // IDLE    | waiting for a save/load start edge
  // S_HDR   | header loaded into ss_dout, raise request once ack is low
  // S_REQ   | save write request outstanding
  // S_ACKLO | save: waiting for ack to drop, then pick next word or finish
  // S_RD    | local memory read strobe
  // S_RDW   | read data returning, latch into ss_dout and request
  // L_REQ   | load read request outstanding
  // L_ACKLO | load: waiting for ack to drop, check header or write word back
  // DONE    | drop busy, back to IDLE
  typedef enum logic [3:0] {
    IDLE, S_HDR, S_REQ, S_ACKLO, S_RD, S_RDW, L_REQ, L_ACKLO, DONE
  } state_t;

  localparam logic [16:0] LAST_IDX = 17'(WORD_COUNT);
  localparam logic [15:0] WC16     = 16'(WORD_COUNT);
  localparam logic [63:0] HEADER   = {MAGIC, 16'h0, WC16};

  state_t      state;
  logic        save_q;
  logic        load_q;
  logic [16:0] idx;
  logic [63:0] cap;
  logic        save_rise;
  logic        load_rise;
  logic        hdr_ok;

  assign save_rise  = ss_save & ~save_q;
  assign load_rise  = ss_load & ~load_q;
  assign hdr_ok     = (cap[63:32] == MAGIC) && (cap[15:0] == WC16);
  assign ss_be      = {8{ss_req}};
  assign ss_addr    = ss_req ? (ADDR_BASE + {6'd0, idx, 3'd0}) : 26'd0;
  assign core_pause = ss_busy;

  always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      save_q    <= 1'b0;
      load_q    <= 1'b0;
      idx       <= 17'd0;
      cap       <= 64'd0;
      ss_req    <= 1'b0;
      ss_rnw    <= 1'b0;
      ss_dout   <= 64'd0;
      ss_busy   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 64'd0;
      load_err  <= 1'b0;
    end else begin
      save_q   <= ss_save;
      load_q   <= ss_load;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (load_rise) begin
            ss_busy <= 1'b1;
            ss_rnw  <= 1'b1;
            ss_req  <= ~ss_ack;
            idx     <= 17'd0;
            state   <= L_REQ;
          end else if (save_rise) begin
            ss_busy <= 1'b1;
            ss_rnw  <= 1'b0;
            ss_dout <= HEADER;
            idx     <= 17'd0;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (!ss_ack) begin
            ss_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        // A request only rises with ack low, so a stuck ack is never taken as completion
        S_REQ: begin
          if (!ss_req) begin
            if (!ss_ack) ss_req <= 1'b1;
          end else if (ss_ack) begin
            ss_req <= 1'b0;
            state  <= S_ACKLO;
          end
        end
        S_ACKLO: begin
          if (!ss_ack) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx      <= idx + 17'd1;
              mem_rd   <= 1'b1;
              mem_addr <= idx[15:0];
              state    <= S_RD;
            end
          end
        end
        S_RD: state <= S_RDW;
        S_RDW: begin
          ss_dout <= mem_rdata;
          ss_req  <= ~ss_ack;
          state   <= S_REQ;
        end
        L_REQ: begin
          if (!ss_req) begin
            if (!ss_ack) ss_req <= 1'b1;
          end else if (ss_ack) begin
            cap    <= ss_din;
            ss_req <= 1'b0;
            state  <= L_ACKLO;
          end
        end
        L_ACKLO: begin
          if (!ss_ack) begin
            if (idx == 17'd0 && !hdr_ok) begin
              load_err <= 1'b1;
              state    <= DONE;
            end else begin
              if (idx != 17'd0) begin
                mem_wr    <= 1'b1;
                mem_addr  <= 16'(idx - 17'd1);
                mem_wdata <= cap;
              end
              if (idx == LAST_IDX) begin
                state <= DONE;
              end else begin
                idx    <= idx + 17'd1;
                ss_req <= 1'b1;
                state  <= L_REQ;
              end
            end
          end
        end
        DONE: begin
          ss_busy <= 1'b0;
          ss_req  <= 1'b0;
          ss_rnw  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_save_state_initiator.sv
// Bench for save_state_initiator: behavioural controller/memory model, image-level
// expectations for save and load, randomized ack timing and header corruption.
module tb_save_state_initiator;
  localparam int          WC    = 4;
  localparam logic [31:0] MAGIC = 32'h4E455331;
  localparam logic [63:0] HDR   = {MAGIC, 32'h0000_0004};

  typedef struct packed {logic rnw; logic [25:0] addr; logic [63:0] data;} req_t;
  typedef struct packed {logic [15:0] addr; logic [63:0] data;} wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ss_save = 1'b0;
  logic        ss_load = 1'b0;
  logic        ss_ack = 1'b0;
  logic [63:0] ss_din = 64'd0;
  logic [63:0] mem_rdata = 64'd0;
  logic        ss_req, ss_rnw, ss_busy, core_pause, mem_rd, mem_wr, load_err;
  logic [25:0] ss_addr;
  logic [7:0]  ss_be;
  logic [63:0] ss_dout, mem_wdata;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  save_state_initiator #(.WORD_COUNT(WC), .ADDR_BASE(26'h0), .MAGIC(MAGIC)) dut (
    .clk_ppu_21_47(clk), .reset_n(reset_n), .ss_save(ss_save), .ss_load(ss_load),
    .ss_req(ss_req), .ss_rnw(ss_rnw), .ss_addr(ss_addr), .ss_be(ss_be),
    .ss_dout(ss_dout), .ss_din(ss_din), .ss_ack(ss_ack), .ss_busy(ss_busy),
    .core_pause(core_pause), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .load_err(load_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // controller / memory model state
  int          lat = 10, wid = 4, glitch_len = 3;
  bit          glitch_en = 1'b0, glitch_pend = 1'b0, is_glitch = 1'b0;
  bit          in_req = 1'b0, prev_req = 1'b0, prev_busy = 1'b0;
  int          ack_left = 0, wait_left = 0;
  int          busy_falls = 0, pause_bad = 0, err_pulses = 0;
  req_t        req_log[$];
  wr_t         wr_log[$];
  logic [63:0] din_q[$];
  logic [63:0] mem[WC];
  logic [63:0] mem_before[WC];
  logic [63:0] load_words[WC+1];

  always @(negedge clk) begin
    if (prev_busy && !ss_busy) busy_falls++;
    prev_busy = ss_busy;
    if (core_pause !== ss_busy) pause_bad++;
    if (load_err) err_pulses++;
    if (mem_wr) begin
      chk("wr_range", 64'(mem_addr < 16'(WC)), 64'd1);
      mem[mem_addr[1:0]] = mem_wdata;
      wr_log.push_back('{mem_addr, mem_wdata});
    end
    if (mem_rd) begin
      chk("rd_range", 64'(mem_addr < 16'(WC)), 64'd1);
      mem_rdata = mem[mem_addr[1:0]];
    end
    if (!reset_n) begin
      ss_ack = 1'b0; in_req = 1'b0; ack_left = 0; glitch_pend = 1'b0;
      is_glitch = 1'b0; prev_req = 1'b0;
    end else begin
      if (ss_req && !prev_req) chk("req_rise_ack_low", 64'(ss_ack), 64'd0);
      prev_req = ss_req;
      if (ss_ack) begin
        ack_left--;
        if (ack_left <= 0) begin
          ss_ack = 1'b0;
          glitch_pend = glitch_en && !is_glitch;
          is_glitch = 1'b0;
        end
      end else if (glitch_pend) begin
        // spurious ack while no request is pending, overlapping the next issue
        glitch_pend = 1'b0;
        if (!ss_req) begin
          ss_ack = 1'b1; ack_left = glitch_len; is_glitch = 1'b1;
        end
      end else if (ss_req && !in_req) begin
        in_req = 1'b1;
        wait_left = lat;
        req_log.push_back('{ss_rnw, ss_addr, ss_dout});
        chk("req_be", 64'(ss_be), 64'hFF);
      end else if (in_req) begin
        wait_left--;
        if (wait_left <= 0) begin
          chk("req_hold_addr", 64'({ss_req, ss_rnw, ss_addr}),
              64'({1'b1, req_log[$].rnw, req_log[$].addr}));
          chk("req_hold_data", ss_dout, req_log[$].data);
          ss_ack = 1'b1;
          ack_left = wid;
          in_req = 1'b0;
          if (din_q.size() > 0) ss_din = din_q.pop_front();
          else ss_din = 64'd0;
        end
      end
    end
  end

  task automatic clear_logs();
    req_log.delete(); wr_log.delete(); din_q.delete();
    busy_falls = 0; pause_bad = 0; err_pulses = 0;
  endtask

  task automatic pulse_start(input bit sv, input bit ld);
    @(negedge clk);
    ss_save = sv; ss_load = ld;
    repeat (3) @(negedge clk);
    ss_save = 1'b0; ss_load = 1'b0;
  endtask

  task automatic wait_op(input string tag);
    int n;
    n = 0;
    while (!ss_busy && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_busy_rise"}, 64'(ss_busy), 64'd1);
    n = 0;
    while (ss_busy && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_busy_fall"}, 64'(ss_busy), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_save(input string tag);
    logic [63:0] exp_d;
    chk({tag, "_nreq"}, 64'(req_log.size()), 64'(WC + 1));
    for (int k = 0; k < req_log.size() && k <= WC; k++) begin
      chk({tag, "_addr"}, 64'({req_log[k].rnw, req_log[k].addr}), 64'(k * 8));
      if (k == 0) exp_d = HDR;
      else exp_d = mem[k-1];
      chk({tag, "_dout"}, req_log[k].data, exp_d);
    end
    chk({tag, "_falls"}, 64'(busy_falls), 64'd1);
    chk({tag, "_pause"}, 64'(pause_bad), 64'd0);
    chk({tag, "_nwr"}, 64'(wr_log.size()), 64'd0);
    chk({tag, "_err"}, 64'(err_pulses), 64'd0);
  endtask

  task automatic check_load(input string tag);
    bit ok;
    int nreq;
    ok = (load_words[0][63:32] == MAGIC) && (load_words[0][15:0] == 16'(WC));
    nreq = ok ? WC + 1 : 1;
    chk({tag, "_nreq"}, 64'(req_log.size()), 64'(nreq));
    for (int k = 0; k < req_log.size() && k < nreq; k++)
      chk({tag, "_addr"}, 64'({req_log[k].rnw, req_log[k].addr}), 64'({1'b1, 26'(k * 8)}));
    chk({tag, "_nwr"}, 64'(wr_log.size()), ok ? 64'(WC) : 64'd0);
    for (int k = 0; k < wr_log.size() && k < WC; k++) begin
      chk({tag, "_wr_addr"}, 64'(wr_log[k].addr), 64'(k));
      chk({tag, "_wr_data"}, wr_log[k].data, load_words[k+1]);
    end
    chk({tag, "_err"}, 64'(err_pulses), ok ? 64'd0 : 64'd1);
    for (int i = 0; i < WC; i++)
      chk({tag, "_mem"}, mem[i], ok ? load_words[i+1] : mem_before[i]);
    chk({tag, "_falls"}, 64'(busy_falls), 64'd1);
    chk({tag, "_pause"}, 64'(pause_bad), 64'd0);
  endtask

  task automatic run_save(input string tag);
    clear_logs();
    pulse_start(1'b1, 1'b0);
    wait_op(tag);
    check_save(tag);
  endtask

  task automatic run_load(input string tag, input bit sv_too);
    clear_logs();
    for (int i = 0; i < WC; i++) mem_before[i] = mem[i];
    for (int k = 0; k <= WC; k++) din_q.push_back(load_words[k]);
    pulse_start(sv_too, 1'b1);
    wait_op(tag);
    check_load(tag);
  endtask

  task automatic make_load(input bit valid);
    logic [31:0] fm;
    load_words[0] = {MAGIC, 16'($urandom), 16'(WC)};
    if (!valid) begin
      fm = 32'h1 << $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) load_words[0][63:32] = load_words[0][63:32] ^ fm;
      else load_words[0][15:0] = load_words[0][15:0] ^ fm[15:0] ^ fm[31:16];
    end
    for (int k = 1; k <= WC; k++) load_words[k] = {$urandom, $urandom};
  endtask

  task automatic rand_mem();
    for (int i = 0; i < WC; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({ss_req, ss_rnw, ss_busy, core_pause, mem_rd, mem_wr, load_err, ss_be}), 64'd0);
    chk({tag, "_addr"}, 64'({ss_addr, mem_addr}), 64'd0);
    chk({tag, "_dout"}, ss_dout, 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // directed save: A..D, 10-cycle latency, 4-cycle ack
    mem[0] = 64'hAAAA_0000_0000_000A; mem[1] = 64'hBBBB_0000_0000_000B;
    mem[2] = 64'hCCCC_0000_0000_000C; mem[3] = 64'hDDDD_0000_0000_000D;
    lat = 10; wid = 4; glitch_en = 1'b0;
    run_save("dsave");

    // directed valid load
    load_words[0] = HDR;
    for (int k = 1; k <= WC; k++) load_words[k] = 64'h5700_0000_0000_0000 | 64'(k - 1);
    run_load("dload", 1'b0);

    // directed bad header
    load_words[0] = 64'h12345678_00000004;
    run_load("dbadhdr", 1'b0);

    // simultaneous start edges plus a late save edge
    make_load(1'b1);
    clear_logs();
    for (int i = 0; i < WC; i++) mem_before[i] = mem[i];
    for (int k = 0; k <= WC; k++) din_q.push_back(load_words[k]);
    @(negedge clk);
    ss_save = 1'b1; ss_load = 1'b1;
    repeat (2) @(negedge clk);
    ss_save = 1'b0; ss_load = 1'b0;
    repeat (15) @(negedge clk);
    ss_save = 1'b1;
    repeat (2) @(negedge clk);
    ss_save = 1'b0;
    wait_op("both");
    check_load("both");
    repeat (20) @(negedge clk);
    chk("both_idle_busy", 64'(ss_busy), 64'd0);
    chk("both_idle_nreq", 64'(req_log.size()), 64'(WC + 1));

    // stuck ack overlapping request issue
    rand_mem();
    lat = 3; wid = 2; glitch_en = 1'b1; glitch_len = 4;
    run_save("stuck");
    glitch_en = 1'b0;

    // reset during the third save request
    rand_mem();
    lat = 10; wid = 4;
    clear_logs();
    pulse_start(1'b1, 1'b0);
    n = 0;
    while (req_log.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    chk("rst_reach_req3", 64'(req_log.size()), 64'd3);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_save("after_rst");

    // randomized operations
    for (int t = 0; t < 14; t++) begin
      lat = $urandom_range(1, 12);
      wid = $urandom_range(1, 5);
      glitch_en = ($urandom_range(0, 2) == 0);
      glitch_len = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        rand_mem();
        run_save("rsave");
      end else begin
        make_load($urandom_range(0, 3) != 0);
        run_load("rload", 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/save_state_initiator.md
Name: save_state_initiator

Overview:
- Initiator side of the 64-bit save-state bus (ss_req/ss_rnw/ss_addr/ss_be/ss_dout/ss_din/ss_ack/ss_busy).
- Serializes a core-local state memory into the save-state controller on ss_save, and restores it on ss_load.
- Word 0 of every image is a header; words 1..WORD_COUNT are payload.
- Sits in the core clock domain between the emulated core's state RAM/register file and the save-state controller.

Parameters:
- WORD_COUNT, 512: number of 64-bit payload words; range 1..65535.
- ADDR_BASE, 26'h0: byte address of the header word on the ss bus.
- MAGIC, 32'h4E455331: header tag stored in header[63:32].

Ports:
- clk_ppu_21_47 in 1: core clock; all logic on posedge.
- reset_n in 1: asynchronous active-low reset.
- ss_save in 1: save start level from the controller; rising edge triggers a save.
- ss_load in 1: load start level from the controller; rising edge triggers a load.
- ss_req out 1: request valid.
- ss_rnw out 1: 1 = read (load), 0 = write (save).
- ss_addr out 26: byte address = ADDR_BASE + 8*word_index.
- ss_be out 8: byte enables; constant 8'hFF while ss_req is high, otherwise 0.
- ss_dout out 64: write data for a save.
- ss_din in 64: read data for a load; valid on the first ss_ack-high cycle.
- ss_ack in 1: completion from the controller; may stay high for several cycles.
- ss_busy out 1: high for the entire save or load operation.
- core_pause out 1: equal to ss_busy; freezes the core.
- mem_rd out 1: local memory read strobe.
- mem_wr out 1: local memory write strobe.
- mem_addr out 16: payload index, 0..WORD_COUNT-1.
- mem_wdata out 64: local memory write data.
- mem_rdata in 64: local memory read data; valid one cycle after mem_rd.
- load_err out 1: one-cycle pulse when a loaded header mismatches.

Behaviour:
- Reset values: all outputs 0; state IDLE; edge-detect registers 0.
- Edge detection:
  - Rising edges of ss_save and ss_load are detected against the previous-cycle value.
  - Edges are acted on only in IDLE; edges seen in any other state are ignored.
  - If both rise in the same cycle, load wins.
- Index counter idx is 17 bits, 0..WORD_COUNT. idx 0 is the header; idx k maps to mem_addr = k-1.
- Save path:
  - IDLE -> S_HDR: ss_busy = 1. ss_dout = {MAGIC, 16'h0, WORD_COUNT[15:0]}, ss_rnw = 0, ss_req = 1, idx = 0.
  - S_REQ: hold ss_req, ss_addr and ss_dout stable until the first cycle ss_ack = 1. Next cycle ss_req = 0 -> S_ACKLO.
  - S_ACKLO: wait until ss_ack = 0, so repeated ack cycles count as one completion.
    - If idx == WORD_COUNT -> DONE.
    - Else idx++ and -> S_RD.
  - S_RD: mem_rd = 1 for 1 cycle with mem_addr = idx-1 -> S_RDW.
  - S_RDW: latch mem_rdata into ss_dout, assert ss_req -> S_REQ.
- Load path:
  - IDLE -> L_REQ: ss_busy = 1, ss_rnw = 1, ss_req = 1, idx = 0.
  - L_REQ: on the first ss_ack = 1 cycle, capture ss_din; next cycle ss_req = 0 -> L_ACKLO.
  - L_ACKLO: wait for ss_ack = 0.
    - If idx == 0 and captured {MAGIC, WORD_COUNT[15:0]} mismatches: pulse load_err for 1 cycle -> DONE. No mem_wr occurs.
    - If idx > 0: mem_wr = 1 for 1 cycle with mem_addr = idx-1 and mem_wdata = captured word.
    - Then if idx == WORD_COUNT -> DONE; else idx++, re-assert ss_req -> L_REQ.
  - Header bits [31:16] are ignored on load.
- DONE: ss_busy = 0, ss_req = 0 -> IDLE. The controller finishes on the ss_busy falling edge.
- Request timing:
  - Minimum gap between a request's ack and the next ss_req rise is 2 cycles.
  - ss_req never rises while ss_ack is high.
- ss_ack seen while ss_req = 0 is ignored.
- No timeout: the block waits on ss_ack indefinitely.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. Any partial load stays in local memory; no further writes occur.

Test Plan:
- Save, WORD_COUNT=4, mem = {A,B,C,D}; controller acks each request after 10 cycles with a 4-cycle-wide ack -> exactly 5 requests:
  - ss_addr 0,8,16,24,32 with ss_rnw = 0;
  - ss_dout = 4E455331_00000004, then A, B, C, D;
  - ss_busy falls once after the 5th ack clears; core_pause tracks ss_busy.
- Load, WORD_COUNT=4; controller returns header 4E455331_00000004, then W0..W3 -> mem_wr at addr 0..3 with W0..W3; load_err stays 0; ss_busy falls afterwards.
- Load with header 12345678_00000004 -> one request only; load_err pulses 1 cycle; no mem_wr; ss_busy falls.
- ss_save and ss_load rise in the same cycle -> load sequence runs (ss_rnw = 1). A second ss_save edge mid-load is ignored.
- reset_n low during the 3rd save request -> all outputs 0 asynchronously. After release plus a new ss_save edge, a full save restarts at ss_addr 0.
- ss_ack held high across request issue (stuck ack from the prior word) -> next ss_req is withheld until ss_ack is low.
